// File: rtl/piu_pchidx_iter.sv
// -----------------------------------------------------------------------------
// PiuPchidxIter: sequential patch-index iterator.
//
// Latches one patch bitmask chosen from NUM_SRC flattened source vectors, then
// hands out every set bit index exactly once over a valid/ready stream. Two
// issue orders: ascending from bit 0, or round-robin starting just after the
// last index handed out in any earlier run. The PIU control FSM drives
// start/abort; the per-patch instruction issue path consumes the indices.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   start_valid_i  request to load a new mask
//   start_ready_o  a start can be accepted (IDLE)
//   sel_src_i      source select; values >= NUM_SRC select an all-zero mask
//   src_vec_i      flattened sources, source k at [k*NUM_PCH +: NUM_PCH]
//   mode_i         0 = ascending, 1 = round-robin (sampled at start)
//   abort_i        abandon the current run (only honoured while iterating)
//   idx_valid_o    pchidx_o is valid
//   idx_ready_i    consumer accepts pchidx_o
//   pchidx_o       current patch index
//   idx_last_o     pchidx_o is the final set bit of the run
//   remain_cnt_o   set bits still pending
//   busy_o         not IDLE
//   done_o         one-cycle pulse when a run completes normally
// -----------------------------------------------------------------------------
module piu_pchidx_iter #(
  parameter int NUM_PCH    = 16,
  parameter int PCHADDR_BW = $clog2(NUM_PCH),
  parameter int NUM_SRC    = 4,
  parameter int SEL_BW     = $clog2(NUM_SRC)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_valid_i,
  output logic                       start_ready_o,
  input  logic [SEL_BW-1:0]          sel_src_i,
  input  logic [NUM_SRC*NUM_PCH-1:0] src_vec_i,
  input  logic                       mode_i,
  input  logic                       abort_i,
  output logic                       idx_valid_o,
  input  logic                       idx_ready_i,
  output logic [PCHADDR_BW-1:0]      pchidx_o,
  output logic                       idx_last_o,
  output logic [PCHADDR_BW:0]        remain_cnt_o,
  output logic                       busy_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_PCH-1:0]      mask_q, mask_d;
  logic [PCHADDR_BW-1:0]   rr_ptr_q, rr_ptr_d;
  logic                    mode_q, mode_d;
  logic [PCHADDR_BW:0]     remain_q, remain_d;

  logic [NUM_PCH-1:0]      src_mask;
  logic [PCHADDR_BW:0]     src_pop;
  logic [PCHADDR_BW-1:0]   pick;
  logic [PCHADDR_BW-1:0]   pick_next;

  // Source selection by equality match, so an out-of-range select simply
  // matches nothing and leaves the mask at zero.
  always_comb begin
    src_mask = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(sel_src_i) == k) begin
        src_mask = src_vec_i[k*NUM_PCH +: NUM_PCH];
      end
    end
  end

  // Popcount of the selected source, loaded as the run length at start.
  always_comb begin
    src_pop = '0;
    for (int i = 0; i < NUM_PCH; i++) begin
      src_pop = src_pop + {{PCHADDR_BW{1'b0}}, src_mask[i]};
    end
  end

  // Index picker. Both scans run from the far end toward the preferred start
  // so the last match written (the one closest to the start) wins.
  always_comb begin
    pick = '0;
    if (!mode_q) begin
      for (int i = NUM_PCH-1; i >= 0; i--) begin
        if (mask_q[i]) begin
          pick = PCHADDR_BW'(i);
        end
      end
    end else begin
      for (int k = NUM_PCH-1; k >= 0; k--) begin
        if (mask_q[(int'(rr_ptr_q) + k) % NUM_PCH]) begin
          pick = PCHADDR_BW'((int'(rr_ptr_q) + k) % NUM_PCH);
        end
      end
    end
  end

  // Round-robin pointer successor with wrap at NUM_PCH-1.
  always_comb begin
    if (pick == PCHADDR_BW'(NUM_PCH-1)) begin
      pick_next = '0;
    end else begin
      pick_next = pick + PCHADDR_BW'(1);
    end
  end

  // Next-state and output logic. Abort overrides the state transition but a
  // coincident handshake still consumes its index and moves rr_ptr.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    rr_ptr_d      = rr_ptr_q;
    mode_d        = mode_q;
    remain_d      = remain_q;
    start_ready_o = 1'b0;
    idx_valid_o   = 1'b0;
    pchidx_o      = '0;
    idx_last_o    = 1'b0;
    done_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          mask_d   = src_mask;
          mode_d   = mode_i;
          remain_d = src_pop;
          state_d  = (src_mask != '0) ? ITER : DONE;
        end
      end
      ITER: begin
        idx_valid_o = 1'b1;
        pchidx_o    = pick;
        idx_last_o  = (remain_q == (PCHADDR_BW+1)'(1));
        if (idx_ready_i) begin
          mask_d[pick] = 1'b0;
          remain_d     = remain_q - (PCHADDR_BW+1)'(1);
          rr_ptr_d     = pick_next;
          if (remain_q == (PCHADDR_BW+1)'(1)) begin
            state_d = DONE;
          end
        end
        if (abort_i) begin
          mask_d   = '0;
          remain_d = '0;
          state_d  = IDLE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o       = (state_q != IDLE);
  assign remain_cnt_o = remain_q;

  // State register with synchronous reset; rr_ptr is only cleared here so it
  // carries across runs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      rr_ptr_q <= '0;
      mode_q   <= 1'b0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      rr_ptr_q <= rr_ptr_d;
      mode_q   <= mode_d;
      remain_q <= remain_d;
    end
  end

endmodule

// File: tb/tb_piu_pchidx_iter.sv
// -----------------------------------------------------------------------------
// Testbench for piu_pchidx_iter. A stimulus process issues runs and pushes the
// expected index stream into a queue; a monitor on the falling edge compares
// every presented index against the queue head and pops on handshakes.
// -----------------------------------------------------------------------------
module tb_piu_pchidx_iter;

  localparam int NPCH = 16;
  localparam int AW   = 4;
  localparam int NSRC = 3;
  localparam int SELW = 2;

  typedef struct {
    int idx;
    int last;
    int remain;
  } exp_t;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 start_valid_i = 1'b0;
  logic                 start_ready_o;
  logic [SELW-1:0]      sel_src_i = '0;
  logic [NSRC*NPCH-1:0] src_vec_i = '0;
  logic                 mode_i = 1'b0;
  logic                 abort_i = 1'b0;
  logic                 idx_valid_o;
  logic                 idx_ready_i = 1'b0;
  logic [AW-1:0]        pchidx_o;
  logic                 idx_last_o;
  logic [AW:0]          remain_cnt_o;
  logic                 busy_o;
  logic                 done_o;

  int   checks = 0;
  int   errors = 0;
  int   doneSeen = 0;
  int   expDone = 0;
  int   rrModel = 0;
  bit   prevDone = 1'b0;
  exp_t expQ[$];
  int   runOrder[$];
  bit   readyPat[$];

  piu_pchidx_iter #(
    .NUM_PCH(NPCH), .PCHADDR_BW(AW), .NUM_SRC(NSRC), .SEL_BW(SELW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
    .sel_src_i(sel_src_i), .src_vec_i(src_vec_i), .mode_i(mode_i),
    .abort_i(abort_i), .idx_valid_o(idx_valid_o), .idx_ready_i(idx_ready_i),
    .pchidx_o(pchidx_o), .idx_last_o(idx_last_o), .remain_cnt_o(remain_cnt_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Single comparison point feeding the summary counters.
  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference issue order: the set bits of the mask, either sorted ascending
  // or the same sorted list rotated to begin at the first bit >= rrModel.
  // Each entry also records its last flag and pending count.
  function automatic void pushRun(input logic [NPCH-1:0] m, input bit md);
    int sorted[$];
    int rot;
    runOrder.delete();
    for (int i = 0; i < NPCH; i++) if (m[i]) sorted.push_back(i);
    rot = 0;
    if (md) begin
      rot = sorted.size();
      for (int i = sorted.size()-1; i >= 0; i--) if (sorted[i] >= rrModel) rot = i;
      if (rot == sorted.size()) rot = 0;
    end
    for (int i = 0; i < sorted.size(); i++) runOrder.push_back(sorted[(rot + i) % sorted.size()]);
    for (int i = 0; i < runOrder.size(); i++)
      expQ.push_back('{runOrder[i], (i == runOrder.size()-1) ? 1 : 0, runOrder.size() - i});
  endfunction

  // Issue one run and drive the consumer until the DUT returns to IDLE.
  // abortAt = 0: no abort; n > 0: abort alongside handshake slot n;
  // -1: pick a random slot. abortHs chooses whether that slot also handshakes.
  task automatic applyStimulus(input int sel, input logic [NSRC*NPCH-1:0] vec, input bit md,
                               input int readyPct, input int abortAt, input bit abortHs,
                               input bit idleAbort);
    logic [NPCH-1:0] m;
    logic [63:0]     junk;
    int pop, hs, cyc, d, ab;
    bit ready, v;
    m = (sel < NSRC) ? vec[sel*NPCH +: NPCH] : '0;
    pushRun(m, md);
    pop = runOrder.size();
    ab = abortAt;
    if (ab < 0) ab = (pop > 0) ? $urandom_range(pop, 1) : 0;
    if (ab > pop) ab = 0;
    checkOutput("start_ready", int'(start_ready_o), 1);
    sel_src_i = SELW'(sel);
    src_vec_i = vec;
    mode_i = md;
    abort_i = idleAbort;
    start_valid_i = 1'b1;
    @(posedge clk_i); #1;
    start_valid_i = 1'b0;
    abort_i = 1'b0;
    junk = {$urandom, $urandom};
    src_vec_i = junk[NSRC*NPCH-1:0];
    sel_src_i = SELW'($urandom_range(3));
    mode_i = $urandom_range(1);
    if (pop == 0) checkOutput("empty_done_latency", int'(done_o), 1);
    else checkOutput("first_valid_latency", int'(idx_valid_o), 1);
    hs = 0;
    cyc = 0;
    while (busy_o && cyc < 200) begin
      if (readyPat.size() > 0) ready = readyPat.pop_front();
      else ready = ($urandom_range(99) < readyPct);
      v = idx_valid_o;
      if (ab > 0 && v && hs == ab-1) begin
        abort_i = 1'b1;
        ready = abortHs;
      end
      idx_ready_i = ready;
      @(posedge clk_i); #1;
      if (v && ready) hs++;
      abort_i = 1'b0;
      cyc++;
    end
    idx_ready_i = 1'b0;
    readyPat.delete();
    if (busy_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout: busy still %0d, expected 0 at %0t", busy_o, $time);
    end
    if (ab > 0) begin
      d = abortHs ? ab : ab-1;
      checkOutput("abort_leftover", expQ.size(), pop - d);
      checkOutput("abort_to_idle", int'({busy_o, start_ready_o}), 1);
      expQ.delete();
    end else begin
      d = pop;
      checkOutput("run_drained", expQ.size(), 0);
      expDone++;
    end
    checkOutput("handshake_count", hs, d);
    if (d > 0) rrModel = (runOrder[d-1] + 1) % NPCH;
  endtask

  // Monitor: compares every presented index against the scoreboard head and
  // checks the done pulse shape.
  initial begin
    forever begin
      @(negedge clk_i);
      if (idx_valid_o) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_idx: got idx %0d, expected no valid at %0t", pchidx_o, $time);
        end else begin
          checkOutput("pchidx", int'(pchidx_o), expQ[0].idx);
          checkOutput("idx_last", int'(idx_last_o), expQ[0].last);
          checkOutput("remain_cnt", int'(remain_cnt_o), expQ[0].remain);
          if (idx_ready_i) void'(expQ.pop_front());
        end
      end
      if (done_o) begin
        doneSeen++;
        checkOutput("done_state", int'({idx_valid_o, start_ready_o, busy_o}), 1);
        checkOutput("done_width", int'(prevDone), 0);
      end
      prevDone = done_o;
    end
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset-state check shared by power-on and mid-run reset.
  task automatic checkResetState();
    checkOutput("rst_idx_valid", int'(idx_valid_o), 0);
    checkOutput("rst_busy", int'(busy_o), 0);
    checkOutput("rst_done", int'(done_o), 0);
    checkOutput("rst_pchidx", int'(pchidx_o), 0);
    checkOutput("rst_remain", int'(remain_cnt_o), 0);
    checkOutput("rst_idx_last", int'(idx_last_o), 0);
    checkOutput("rst_start_ready", int'(start_ready_o), 1);
  endtask

  initial begin
    logic [63:0] r1, r2;
    logic [NSRC*NPCH-1:0] vec;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    checkResetState();

    // Ascending, full-rate consumer.
    applyStimulus(0, {32'h0, 16'h8421}, 1'b0, 100, 0, 1'b0, 1'b0);
    // Backpressure pattern on the same mask.
    readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    applyStimulus(0, {32'h0, 16'h8421}, 1'b0, 100, 0, 1'b0, 1'b0);
    // Round-robin continuing after an ascending run.
    applyStimulus(0, {32'h0, 16'h0030}, 1'b0, 100, 0, 1'b0, 1'b0);
    applyStimulus(0, {32'h0, 16'h8071}, 1'b1, 100, 0, 1'b0, 1'b0);
    // Empty selected source and out-of-range select.
    applyStimulus(1, {16'hFFFF, 16'h0000, 16'hFFFF}, 1'b0, 100, 0, 1'b0, 1'b0);
    applyStimulus(3, {48{1'b1}}, 1'b1, 100, 0, 1'b0, 1'b0);
    // Abort together with the third handshake, then an immediate restart.
    applyStimulus(0, {32'h0, 16'h00FF}, 1'b0, 100, 3, 1'b1, 1'b0);
    applyStimulus(2, {16'h0109, 32'h0}, 1'b1, 100, 0, 1'b0, 1'b0);
    // Abort during a stall (no handshake) in round-robin mode.
    applyStimulus(1, {16'h0, 16'h0F0F, 16'h0}, 1'b1, 60, 2, 1'b0, 1'b0);
    // Abort while IDLE is ignored; the start still proceeds.
    applyStimulus(2, {16'hA5A5, 32'h0}, 1'b0, 70, 0, 1'b0, 1'b1);

    // Reset in the middle of a run, after two handshakes.
    pushRun(16'hF0F0, 1'b0);
    sel_src_i = 2'd2;
    src_vec_i = {16'hF0F0, 32'h0};
    mode_i = 1'b0;
    start_valid_i = 1'b1;
    @(posedge clk_i); #1;
    start_valid_i = 1'b0;
    idx_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 idx_ready_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    expQ.delete();
    rrModel = 0;
    checkResetState();
    // Round-robin order after reset must start scanning from bit 0.
    applyStimulus(0, {32'h0, 16'h0101}, 1'b1, 100, 0, 1'b0, 1'b0);

    // Randomised runs with varied density, mode, backpressure and aborts.
    for (int n = 0; n < 40; n++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      vec = r1[NSRC*NPCH-1:0];
      if ($urandom_range(2) == 0) vec = vec & r2[NSRC*NPCH-1:0];
      applyStimulus($urandom_range(3), vec, 1'(($urandom_range(1))), $urandom_range(100, 30),
                    ($urandom_range(4) == 0) ? -1 : 0, 1'(($urandom_range(1))),
                    1'(($urandom_range(5) == 0)));
    end

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("done_count", doneSeen, expDone);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
